mouse_master_ctrl: RTL and testbench

// - Parametrised PS/2 mouse master FSM, successor to the 3-byte-only controller. Sits between ps2 tx/rx byte engines and bus-side mouse regs.
// - Runs a table-driven init (reset, optional IntelliMouse wheel probe, enable streaming) with ACK timeouts and bounded retries.
// - Assembles 3- or 4-byte packets with sync checking; publishes them atomically, then raises an interrupt.

---
 rtl/mouse_pkg.sv | 21 ++
 rtl/mouse_if.sv | 20 ++
 rtl/mouse_init_rom.sv | 41 ++++
 rtl/mouse_master_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_mouse_master_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// Shared types and PS/2 mouse protocol constants for the mouse master controller.
package mouse_pkg;

    typedef enum logic [3:0] {
        PWRUP, SEND, WAIT_ACK, WAIT_BAT, WAIT_BID, WAIT_ID, FAIL_CHK, STREAM, FAILED
    } state_t;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SETRATE = 8'hF3;
    localparam logic [7:0] CMD_GETID   = 8'hF2;
    localparam logic [7:0] CMD_STREAM  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_BAT     = 8'hAA;
    localparam logic [7:0] ID_WHEEL    = 8'h03;

    // Index of the final byte of a movement packet (3 bytes, or 4 with a wheel).
    function automatic logic [1:0] pkt_last_idx(input logic wheel);
        return wheel ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/mouse_if.sv
// Byte-level handshake between the mouse master FSM and the PS/2 tx/rx engines.
interface mouse_if;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    modport master (
        output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );

    modport slave (
        input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );
endinterface

// File: rtl/mouse_init_rom.sv
// Init command table: maps a sequence index to the command byte and its role flags.
module mouse_init_rom
    import mouse_pkg::*;
#(
    parameter int WHEEL_EN = 1
) (
    input  logic [3:0] idx_i,
    output logic [7:0] cmd_o,
    output logic       last_o,
    output logic       getid_o
);

    // Table lookup; any index past the table end resolves to the enable-streaming entry.
    always_comb begin
        cmd_o   = CMD_STREAM;
        last_o  = 1'b0;
        getid_o = 1'b0;
        if (WHEEL_EN != 0) begin
            case (idx_i)
                4'd0:    cmd_o = CMD_RESET;
                4'd1:    cmd_o = CMD_SETRATE;
                4'd2:    cmd_o = 8'hC8;
                4'd3:    cmd_o = CMD_SETRATE;
                4'd4:    cmd_o = 8'h64;
                4'd5:    cmd_o = CMD_SETRATE;
                4'd6:    cmd_o = 8'h50;
                4'd7: begin
                    cmd_o   = CMD_GETID;
                    getid_o = 1'b1;
                end
                default: last_o = 1'b1;
            endcase
        end else begin
            case (idx_i)
                4'd0:    cmd_o = CMD_RESET;
                default: last_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mouse_master_ctrl.sv
// PS/2 mouse master: table-driven init with ACK timeouts and retries, then
// 3/4-byte packet assembly with sync checking and atomic publication.
module mouse_master_ctrl
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MAX_RETRIES = 3,
    parameter int WHEEL_EN    = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    mouse_if.master     ps2,
    output logic [7:0]  MOUSE_STATUS,
    output logic [7:0]  MOUSE_DX,
    output logic [7:0]  MOUSE_DY,
    output logic [3:0]  MOUSE_DZ,
    output logic        WHEEL_PRESENT,
    output logic        SEND_INTERRUPT,
    input  logic        INTERRUPT_ACK,
    output logic        INIT_FAIL,
    output logic [3:0]  current_state
);

    localparam logic [19:0] TMO_LAST  = 20'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  retry_q, retry_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [19:0] tmo_q;
    logic [7:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [7:0]  status_q, status_d, dx_q, dx_d, dy_q, dy_d;
    logic [3:0]  dz_q, dz_d;
    logic        wheel_q, wheel_d;
    logic        int_q, int_d;
    logic        send_q, send_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        rden_q, rden_d;
    logic        fail_q, fail_d;
    logic        publish_s;
    logic        tmo_hit_s;
    logic        rx_ok_s;
    logic        enter_send_s;
    logic [7:0]  cur_cmd_s, nxt_cmd_s;
    logic        cur_last_s, cur_getid_s, nxt_last_s, nxt_getid_s;
    logic        unused_s;

    // Flags for the entry being acknowledged; the command byte for the entry about to be sent.
    mouse_init_rom #(.WHEEL_EN(WHEEL_EN)) u_rom_cur (
        .idx_i(idx_q), .cmd_o(cur_cmd_s), .last_o(cur_last_s), .getid_o(cur_getid_s)
    );
    mouse_init_rom #(.WHEEL_EN(WHEEL_EN)) u_rom_nxt (
        .idx_i(idx_d), .cmd_o(nxt_cmd_s), .last_o(nxt_last_s), .getid_o(nxt_getid_s)
    );
    assign unused_s = ^{cur_cmd_s, nxt_last_s, nxt_getid_s};

    assign tmo_hit_s = (tmo_q >= TMO_LAST);
    assign rx_ok_s   = ps2.BYTE_READY && (ps2.BYTE_ERROR_CODE == 2'd0);

    // Next-state, init sequencing and packet assembly.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        wheel_d   = wheel_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        status_d  = status_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        dz_d      = dz_q;
        publish_s = 1'b0;
        case (state_q)
            PWRUP: begin
                if (tmo_hit_s) begin
                    idx_d   = 4'd0;
                    state_d = SEND;
                end else begin
                    state_d = PWRUP;
                end
            end
            SEND: begin
                if (ps2.BYTE_SENT) state_d = WAIT_ACK;
                else               state_d = SEND;
            end
            WAIT_ACK: begin
                if (rx_ok_s && ps2.BYTE_READ == RSP_ACK) begin
                    if (idx_q == 4'd0) begin
                        state_d = WAIT_BAT;
                    end else if (cur_getid_s) begin
                        state_d = WAIT_ID;
                    end else if (cur_last_s) begin
                        state_d = STREAM;
                        retry_d = 4'd0;
                        cnt_d   = 2'd0;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SEND;
                    end
                end else if (ps2.BYTE_READY || tmo_hit_s) begin
                    state_d = FAIL_CHK;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            // Self-test can take hundreds of milliseconds, so no timeout here.
            WAIT_BAT: begin
                if (rx_ok_s && ps2.BYTE_READ == RSP_BAT) state_d = WAIT_BID;
                else if (ps2.BYTE_READY)                 state_d = FAIL_CHK;
                else                                     state_d = WAIT_BAT;
            end
            WAIT_BID: begin
                if (rx_ok_s) begin
                    idx_d   = 4'd1;
                    state_d = SEND;
                end else if (ps2.BYTE_READY || tmo_hit_s) begin
                    state_d = FAIL_CHK;
                end else begin
                    state_d = WAIT_BID;
                end
            end
            WAIT_ID: begin
                if (rx_ok_s) begin
                    wheel_d = (ps2.BYTE_READ == ID_WHEEL);
                    idx_d   = idx_q + 4'd1;
                    state_d = SEND;
                end else if (ps2.BYTE_READY || tmo_hit_s) begin
                    state_d = FAIL_CHK;
                end else begin
                    state_d = WAIT_ID;
                end
            end
            FAIL_CHK: begin
                retry_d = retry_q + 4'd1;
                if (retry_d == RETRY_MAX) begin
                    state_d = FAILED;
                end else begin
                    idx_d   = 4'd0;
                    wheel_d = 1'b0;
                    state_d = SEND;
                end
            end
            STREAM: begin
                if (ps2.BYTE_READY && ps2.BYTE_ERROR_CODE != 2'd0) begin
                    cnt_d   = 2'd0;
                    idx_d   = 4'd0;
                    state_d = SEND;
                end else if (ps2.BYTE_READY) begin
                    if (cnt_q == 2'd0 && !ps2.BYTE_READ[3]) begin
                        cnt_d = 2'd0;
                    end else if (cnt_q == pkt_last_idx(wheel_q)) begin
                        status_d  = sh0_q;
                        dx_d      = sh1_q;
                        dy_d      = wheel_q ? sh2_q : ps2.BYTE_READ;
                        dz_d      = wheel_q ? ps2.BYTE_READ[3:0] : 4'h0;
                        publish_s = 1'b1;
                        cnt_d     = 2'd0;
                    end else begin
                        case (cnt_q)
                            2'd0:    sh0_d = ps2.BYTE_READ;
                            2'd1:    sh1_d = ps2.BYTE_READ;
                            default: sh2_d = ps2.BYTE_READ;
                        endcase
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (tmo_hit_s && cnt_q != 2'd0) begin
                    cnt_d = 2'd0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            FAILED:  state_d = FAILED;
            default: state_d = PWRUP;
        endcase
    end

    // Registered-output next values derived from the upcoming state.
    always_comb begin
        enter_send_s = (state_d == SEND) && (state_q != SEND);
        send_d       = enter_send_s;
        cmd_d        = enter_send_s ? nxt_cmd_s : cmd_q;
        rden_d       = !(state_d inside {SEND, FAILED, PWRUP});
        fail_d       = (state_d == FAILED);
        if (INTERRUPT_ACK)  int_d = 1'b0;
        else if (publish_s) int_d = 1'b1;
        else                int_d = int_q;
    end

    // Shared timeout counter: restarts on any state change or received byte, saturates.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tmo_q <= 20'd0;
        end else if (state_d != state_q || ps2.BYTE_READY) begin
            tmo_q <= 20'd0;
        end else if (tmo_q != 20'hF_FFFF) begin
            tmo_q <= tmo_q + 20'd1;
        end else begin
            tmo_q <= tmo_q;
        end
    end

    // FSM state, datapath registers and all registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= PWRUP;
            idx_q    <= 4'd0;
            retry_q  <= 4'd0;
            cnt_q    <= 2'd0;
            wheel_q  <= 1'b0;
            sh0_q    <= 8'h00;
            sh1_q    <= 8'h00;
            sh2_q    <= 8'h00;
            status_q <= 8'h00;
            dx_q     <= 8'h00;
            dy_q     <= 8'h00;
            dz_q     <= 4'h0;
            int_q    <= 1'b0;
            send_q   <= 1'b0;
            cmd_q    <= CMD_RESET;
            rden_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            cnt_q    <= cnt_d;
            wheel_q  <= wheel_d;
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            status_q <= status_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            dz_q     <= dz_d;
            int_q    <= int_d;
            send_q   <= send_d;
            cmd_q    <= cmd_d;
            rden_q   <= rden_d;
            fail_q   <= fail_d;
        end
    end

    assign ps2.SEND_BYTE    = send_q;
    assign ps2.BYTE_TO_SEND = cmd_q;
    assign ps2.READ_ENABLE  = rden_q;
    assign MOUSE_STATUS     = status_q;
    assign MOUSE_DX         = dx_q;
    assign MOUSE_DY         = dy_q;
    assign MOUSE_DZ         = dz_q;
    assign WHEEL_PRESENT    = wheel_q;
    assign SEND_INTERRUPT   = int_q;
    assign INIT_FAIL        = fail_q;
    assign current_state    = state_q;

endmodule

// File: tb/tb_mouse_master_ctrl.sv
// Scoreboard bench for mouse_master_ctrl: a wheel-enabled and a wheel-disabled instance.
module tb_mouse_master_ctrl;
    import mouse_pkg::*;

    localparam int TMO = 64;

    logic clk = 1'b0, rst_n = 1'b0, rst0_n = 1'b0, ack = 1'b0, ack0 = 1'b0;
    logic [7:0] st, dx, dy, st0, dx0, dy0;
    logic [3:0] dz, dz0, cs, cs0;
    logic wheel, intr, fail, wheel0, intr0, fail0;

    mouse_if ifc ();
    mouse_if ifc0 ();

    always #5 clk = ~clk;

    mouse_master_ctrl #(.TIMEOUT_CYC(TMO), .MAX_RETRIES(3), .WHEEL_EN(1)) u_dut (
        .CLK(clk), .RESET(rst_n), .ps2(ifc),
        .MOUSE_STATUS(st), .MOUSE_DX(dx), .MOUSE_DY(dy), .MOUSE_DZ(dz),
        .WHEEL_PRESENT(wheel), .SEND_INTERRUPT(intr), .INTERRUPT_ACK(ack),
        .INIT_FAIL(fail), .current_state(cs)
    );

    mouse_master_ctrl #(.TIMEOUT_CYC(TMO), .MAX_RETRIES(3), .WHEEL_EN(0)) u_dut0 (
        .CLK(clk), .RESET(rst0_n), .ps2(ifc0),
        .MOUSE_STATUS(st0), .MOUSE_DX(dx0), .MOUSE_DY(dy0), .MOUSE_DZ(dz0),
        .WHEEL_PRESENT(wheel0), .SEND_INTERRUPT(intr0), .INTERRUPT_ACK(ack0),
        .INIT_FAIL(fail0), .current_state(cs0)
    );

    int n_vec = 0, n_bad = 0;
    logic [7:0]  exp_cmd[$], exp_cmd0[$];
    logic [27:0] exp_pkt[$];
    logic [7:0]  mdl_buf[$];
    bit          mdl_wheel = 1'b0;
    logic [27:0] mdl_pkt = 28'h0;
    logic        int_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference packet framer: sync on bit3 of the first byte, N = 3 or 4 bytes.
    function automatic bit mdl_feed(input logic [7:0] b);
        int n = mdl_wheel ? 4 : 3;
        if (mdl_buf.size() == 0 && b[3] == 1'b0) return 1'b0;
        mdl_buf.push_back(b);
        if (mdl_buf.size() < n) return 1'b0;
        mdl_pkt = {mdl_buf[0], mdl_buf[1], mdl_buf[2], (n == 4) ? mdl_buf[3][3:0] : 4'h0};
        mdl_buf.delete();
        return 1'b1;
    endfunction

    // Command monitors: every SEND_BYTE pulse must match the next expected command.
    always @(negedge clk) begin
        if (ifc.SEND_BYTE === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_send: got cmd %h with none expected", ifc.BYTE_TO_SEND);
            end else begin
                chk("cmd", 32'(ifc.BYTE_TO_SEND), 32'(exp_cmd.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (ifc0.SEND_BYTE === 1'b1) begin
            if (exp_cmd0.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_send0: got cmd %h with none expected", ifc0.BYTE_TO_SEND);
            end else begin
                chk("cmd0", 32'(ifc0.BYTE_TO_SEND), 32'(exp_cmd0.pop_front()));
            end
        end
    end

    // Packet monitor: each rising interrupt must present the next expected packet.
    always @(negedge clk) begin
        if (intr === 1'b1 && int_prev == 1'b0) begin
            if (exp_pkt.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_packet: got %h with none expected", {st, dx, dy, dz});
            end else begin
                chk("packet", 32'({st, dx, dy, dz}), 32'(exp_pkt.pop_front()));
            end
        end
        int_prev <= intr;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx(input bit s, input logic [7:0] b, input logic [1:0] e, input bit a);
        @(negedge clk);
        if (s) begin
            ifc.BYTE_READ = b; ifc.BYTE_ERROR_CODE = e; ifc.BYTE_READY = 1'b1; ack = a;
        end else begin
            ifc0.BYTE_READ = b; ifc0.BYTE_ERROR_CODE = e; ifc0.BYTE_READY = 1'b1; ack0 = a;
        end
        @(negedge clk);
        ifc.BYTE_READY = 1'b0; ifc0.BYTE_READY = 1'b0; ack = 1'b0; ack0 = 1'b0;
    endtask

    task automatic wait_send(input bit s);
        int k = 0;
        while (!(s ? ifc.SEND_BYTE : ifc0.SEND_BYTE) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            n_vec++; n_bad++;
            $display("FAIL send_timeout: got no SEND_BYTE within %0d cycles, required one", k);
        end
    endtask

    task automatic tx_done(input bit s);
        cyc(3);
        if (s) ifc.BYTE_SENT = 1'b1; else ifc0.BYTE_SENT = 1'b1;
        @(negedge clk);
        ifc.BYTE_SENT = 1'b0; ifc0.BYTE_SENT = 1'b0;
    endtask

    // Plays the mouse side of a full init; expected commands come from the init table.
    task automatic do_init(input bit s, input logic [7:0] id);
        logic [7:0] seq[$];
        if (s) seq = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
        else   seq = '{8'hFF, 8'hF4};
        foreach (seq[i]) begin
            if (s) exp_cmd.push_back(seq[i]); else exp_cmd0.push_back(seq[i]);
        end
        for (int i = 0; i < seq.size(); i++) begin
            wait_send(s);
            tx_done(s);
            rx(s, RSP_ACK, 2'd0, 1'b0);
            if (seq[i] == CMD_RESET) begin
                rx(s, RSP_BAT, 2'd0, 1'b0);
                rx(s, 8'h00, 2'd0, 1'b0);
            end
            if (seq[i] == CMD_GETID) rx(s, id, 2'd0, 1'b0);
        end
        if (s) begin
            mdl_wheel = (id == ID_WHEEL);
            mdl_buf.delete();
        end
        cyc(3);
    endtask

    task automatic feed(input logic [7:0] b);
        bit done;
        done = mdl_feed(b);
        if (done) exp_pkt.push_back(mdl_pkt);
        rx(1'b1, b, 2'd0, 1'b0);
        if (done) begin
            cyc(2);
            @(negedge clk) ack = 1'b1;
            @(negedge clk) ack = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_flags"}, 32'({ifc.SEND_BYTE, ifc.READ_ENABLE, wheel, intr, fail, cs}), 32'h0);
        chk({tag, "_cmd"}, 32'(ifc.BYTE_TO_SEND), 32'hFF);
        chk({tag, "_regs"}, 32'({st, dx, dy, dz}), 32'h0);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        ifc.BYTE_SENT = 1'b0; ifc.BYTE_READ = 8'h00; ifc.BYTE_ERROR_CODE = 2'd0; ifc.BYTE_READY = 1'b0;
        ifc0.BYTE_SENT = 1'b0; ifc0.BYTE_READ = 8'h00; ifc0.BYTE_ERROR_CODE = 2'd0; ifc0.BYTE_READY = 1'b0;
        cyc(3);
        chk_reset("reset");

        // Wheel-disabled instance: FF, F4 only, then 3-byte packets.
        rst0_n = 1'b1;
        do_init(1'b0, 8'h00);
        chk("init0_state", 32'(cs0), 32'(STREAM));
        chk("init0_wheel", 32'(wheel0), 32'h0);
        rx(1'b0, 8'h09, 2'd0, 1'b0);
        rx(1'b0, 8'h01, 2'd0, 1'b0);
        rx(1'b0, 8'h02, 2'd0, 1'b0);
        cyc(1);
        chk("pkt0_regs", 32'({st0, dx0, dy0, dz0}), 32'h0901020);
        chk("pkt0_int", 32'(intr0), 32'h1);

        // Wheel-enabled instance: power-up wait, then full probe sequence.
        rst_n = 1'b1;
        cyc(TMO - 8);
        chk("pwrup_hold", 32'({cs, ifc.READ_ENABLE}), 32'h0);
        do_init(1'b1, ID_WHEEL);
        chk("init_state", 32'(cs), 32'(STREAM));
        chk("init_wheel", 32'(wheel), 32'h1);
        chk("init_rden", 32'(ifc.READ_ENABLE), 32'h1);

        feed(8'h08); feed(8'h05); feed(8'hFB);
        cyc(1);
        chk("int_early", 32'(intr), 32'h0);
        feed(8'h01);
        chk("int_acked", 32'(intr), 32'h0);

        // Resync and inter-byte timeout.
        feed(8'h00); feed(8'h18); feed(8'h02); feed(8'h03); feed(8'h04);
        feed(8'h18); feed(8'h22);
        cyc(TMO + 20);
        mdl_buf.delete();
        chk("gap_hold", 32'({st, dx, dy, dz}), 32'(mdl_pkt));
        feed(8'h28); feed(8'h11); feed(8'h22); feed(8'h03);

        // Random packets.
        for (int i = 0; i < 6; i++) feed(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) feed((i == 0) ? 8'($urandom_range(0, 255)) | 8'h08 : 8'($urandom_range(0, 255)));

        // Interrupt ACK coincident with packet completion.
        if (mdl_buf.size() != 0) begin
            while (mdl_buf.size() != 0) feed(8'h5A);
            @(negedge clk);
        end
        feed(8'h38); feed(8'h44); feed(8'h55);
        done = mdl_feed(8'h06);
        rx(1'b1, 8'h06, 2'd0, 1'b1);
        cyc(1);
        chk("ack_collide_int", 32'(intr), 32'h0);
        chk("ack_collide_regs", 32'({st, dx, dy, dz}), 32'(mdl_pkt));
        chk("ack_collide_done", 32'(done), 32'h1);

        // rx error mid-stream: re-init from FF, last packet held.
        feed(8'h48);
        rx(1'b1, 8'h00, 2'd1, 1'b0);
        mdl_buf.delete();
        chk("err_hold", 32'({st, dx, dy, dz}), 32'(mdl_pkt));
        do_init(1'b1, 8'h00);
        chk("reinit_state", 32'(cs), 32'(STREAM));
        chk("reinit_wheel", 32'(wheel), 32'h0);
        chk("reinit_hold", 32'({st, dx, dy, dz}), 32'(mdl_pkt));
        feed(8'h00); feed(8'h18); feed(8'h02); feed(8'h03);

        // Async reset in STREAM.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_stream");
        mdl_buf.delete();
        mdl_wheel = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        cyc(TMO - 8);
        chk("pwrup_again", 32'(cs), 32'(PWRUP));

        // Async reset in WAIT_ACK.
        exp_cmd.push_back(CMD_RESET);
        wait_send(1'b1);
        tx_done(1'b1);
        cyc(2);
        chk("in_wait_ack", 32'(cs), 32'(WAIT_ACK));
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_wait_ack");
        @(negedge clk) rst_n = 1'b1;

        // No ACK ever: three FF attempts, then terminal failure.
        repeat (3) exp_cmd.push_back(CMD_RESET);
        repeat (3) begin
            wait_send(1'b1);
            tx_done(1'b1);
        end
        cyc(TMO + 20);
        chk("fail_flag", 32'(fail), 32'h1);
        chk("fail_rden", 32'(ifc.READ_ENABLE), 32'h0);
        chk("fail_state", 32'(cs), 32'(FAILED));
        cyc(3 * TMO);
        chk("cmd_queue_drained", 32'(exp_cmd.size() + exp_cmd0.size()), 32'h0);
        chk("pkt_queue_drained", 32'(exp_pkt.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
